// File: rtl/rom_loader.sv
// rom_loader: boot loader that erases the instruction ROM, assembles
// little-endian words from a UART byte stream, writes them from word 0 up,
// and holds the CPU in reset until a checksum-verified frame completes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for SYNC_BYTE, all other bytes ignored
// ST_LEN_LO| expecting low byte of word count N
// ST_LEN_HI| expecting high byte of N, range check against ROM_WORDS
// ST_ERASE | single-cycle ROM erase pulse; a byte here is data byte 0
// ST_DATA  | collecting 4*N data bytes, one write per completed word
// ST_CSUM  | expecting the checksum byte
module rom_loader #(
    parameter int          ROM_WORDS   = 4096,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        erase_en_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int             TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_ERASE,
        ST_DATA,
        ST_CSUM
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_lo_q;
    logic [15:0]     len_q;
    logic [15:0]     len_full;
    logic [15:0]     word_idx_q;
    logic [1:0]      byte_pos_q;
    logic [7:0]      b0_q, b1_q, b2_q;
    logic [7:0]      sum_q;
    logic [TW-1:0]   timer_q;

    logic            sync_hit;
    logic            data_byte;
    logic            csum_byte;
    logic            len_over;
    logic            timeout;
    logic            word_complete;
    logic            csum_ok;
    logic            csum_bad;

    assign len_full      = {byte_i, len_lo_q};
    assign word_complete = data_byte && (byte_pos_q == 2'd3);
    assign csum_ok       = csum_byte && (byte_i == sum_q);
    assign csum_bad      = csum_byte && (byte_i != sum_q);
    assign erase_en_o    = (state_q == ST_ERASE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_d   = state_q;
        sync_hit  = 1'b0;
        data_byte = 1'b0;
        csum_byte = 1'b0;
        len_over  = 1'b0;
        timeout   = (state_q != ST_IDLE) && !byte_valid_i && (timer_q == '0);
        case (state_q)
            ST_IDLE: begin
                if (byte_valid_i && (byte_i == SYNC_BYTE)) begin
                    sync_hit = 1'b1;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_valid_i) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (byte_valid_i) begin
                    if ({1'b0, len_full} > 17'(ROM_WORDS)) begin
                        len_over = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_ERASE;
                    end
                end
            end
            ST_ERASE: begin
                // With an empty frame the only byte left is the checksum.
                if (len_q == 16'd0) begin
                    csum_byte = byte_valid_i;
                    state_d   = byte_valid_i ? ST_IDLE : ST_CSUM;
                end else begin
                    data_byte = byte_valid_i;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                data_byte = byte_valid_i;
                if (byte_valid_i && (byte_pos_q == 2'd3) &&
                    (word_idx_q == len_q - 16'd1))
                    state_d = ST_CSUM;
            end
            ST_CSUM: begin
                csum_byte = byte_valid_i;
                if (byte_valid_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) state_d = ST_IDLE;
    end

    // Inter-byte timeout: down-counter reloaded on every byte and while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                timer_q <= '0;
        else if (state_q == ST_IDLE || byte_valid_i) timer_q <= TIMER_LOAD;
        else if (timer_q != '0)                    timer_q <= timer_q - 1'b1;
    end

    // Length capture, word assembly, checksum and word index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_pos_q <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            sum_q      <= '0;
        end else begin
            if (state_q == ST_LEN_LO && byte_valid_i) len_lo_q <= byte_i;
            if (state_q == ST_LEN_HI && byte_valid_i) len_q    <= len_full;
            if (sync_hit) begin
                byte_pos_q <= '0;
                sum_q      <= '0;
                word_idx_q <= '0;
            end
            if (data_byte) begin
                sum_q      <= sum_q + byte_i;
                byte_pos_q <= byte_pos_q + 2'd1;
                case (byte_pos_q)
                    2'd0:    b0_q <= byte_i;
                    2'd1:    b1_q <= byte_i;
                    2'd2:    b2_q <= byte_i;
                    default: word_idx_q <= word_idx_q + 16'd1;
                endcase
            end
        end
    end

    // Registered ROM write port, status and CPU hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            done_o     <= 1'b0;
            cpu_hold_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            wr_en_o <= word_complete;
            done_o  <= csum_ok;
            if (word_complete) begin
                wr_addr_o <= {14'd0, word_idx_q, 2'b00};
                wr_data_o <= {byte_i, b2_q, b1_q, b0_q};
            end
            if (sync_hit) begin
                err_o      <= 1'b0;
                cpu_hold_o <= 1'b1;
            end
            if (len_over || csum_bad || timeout) err_o <= 1'b1;
            if (csum_ok) cpu_hold_o <= 1'b0;
        end
    end

endmodule
